pixel_histogram: RTL

//  Consumes the parallel pixel stream (pd/fv/lv) from the MIPI-to-CMOS bridge in the pixel clock domain.

---
 rtl/histo_pkg.sv | 18 +
 rtl/hist_ram.sv | 24 ++
 rtl/pixel_histogram.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/histo_pkg.sv
// Shared types and default sizing for the pixel histogram block.
package histo_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        ACCUM,
        DRAIN,
        DUMP
    } state_t;

    localparam int PIX_W_DEF    = 10;
    localparam int BIN_BITS_DEF = 8;
    localparam int CNT_W_DEF    = 20;
    localparam int NBINS        = 1 << BIN_BITS_DEF;
    localparam int CNT_MAX      = (1 << CNT_W_DEF) - 1;

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port bin storage: one write port, one read port with a registered output.
module hist_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pixel_histogram.sv
// Per-frame pixel histogram with clear-on-read dump over a valid/ready port.
// Optional HIST_SUM_EN adds a total-pixel trailer word after the last bin.
module pixel_histogram
    import histo_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int BIN_BITS = BIN_BITS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [PIX_W-1:0]    pix_i,
    input  logic                fv_i,
    input  logic                lv_i,
    output logic [CNT_W-1:0]    hist_data_o,
    output logic [BIN_BITS-1:0] hist_bin_o,
    output logic                hist_valid_o,
    input  logic                hist_ready_i,
    output logic                hist_last_o,
    output logic                busy_o,
    output logic                drop_o
);

    localparam int                  N         = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0] LAST_BIN  = '1;
    localparam logic [CNT_W-1:0]    CNT_ONES  = '1;

    // Handshake: a word transfers on any rising clk_i where hist_valid_o &
    // hist_ready_i; data/bin/last hold steady while valid is high and unaccepted.

    state_t              state;
    logic                fv_q;
    logic                fv_rise;
    logic                fv_fall;
    logic                take_pix;
    logic                accept;
    logic [BIN_BITS-1:0] clr_addr;
    logic [BIN_BITS-1:0] dump_addr;
    logic                drain_cnt;
    logic                dump_ld;
    logic                trailer;

    logic                s0_v, s1_v, s2_v, s3_v;
    logic [BIN_BITS-1:0] s0_bin, s1_bin, s2_bin, s3_bin;
    logic [CNT_W-1:0]    s2_val, s3_val;
    logic [CNT_W-1:0]    s1_old;
    logic [CNT_W-1:0]    s1_new;

    logic                ram_we;
    logic [BIN_BITS-1:0] ram_waddr;
    logic [CNT_W-1:0]    ram_wdata;
    logic [BIN_BITS-1:0] ram_raddr;
    logic [CNT_W-1:0]    rd_data;

    logic                unused_pix_lsbs;

`ifdef HIST_SUM_EN
    logic [CNT_W+BIN_BITS-1:0] total;
`else
    assign trailer = 1'b0;
`endif

    assign unused_pix_lsbs = ^pix_i[PIX_W-BIN_BITS-1:0];

    assign fv_rise  = fv_i & ~fv_q;
    assign fv_fall  = ~fv_i & fv_q;
    assign accept   = hist_valid_o & hist_ready_i;
    // The pixel on the frame-start cycle itself belongs to the frame.
    assign take_pix = fv_i & lv_i & ((state == ACCUM) | ((state == IDLE) & fv_rise));

    // Read data lags its address by one cycle, so two writes can be in flight:
    // the one in S2 now, and the one written on the same edge the read was issued.
    always_comb begin
        if (s2_v && (s2_bin == s1_bin)) begin
            s1_old = s2_val;
        end else if (s3_v && (s3_bin == s1_bin)) begin
            s1_old = s3_val;
        end else begin
            s1_old = rd_data;
        end
        s1_new = (s1_old == CNT_ONES) ? s1_old : s1_old + 1'b1;
    end

    always_comb begin
        ram_we    = s2_v;
        ram_waddr = s2_bin;
        ram_wdata = s2_val;
        ram_raddr = s0_bin;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end else if (state == DUMP) begin
            // Prefetch the next bin on accept so it is ready one cycle later.
            ram_we    = accept & ~trailer;
            ram_waddr = dump_addr;
            ram_wdata = '0;
            ram_raddr = accept ? dump_addr + 1'b1 : dump_addr;
        end
    end

    hist_ram #(
        .DEPTH (N),
        .AW    (BIN_BITS),
        .DW    (CNT_W)
    ) u_ram (
        .clk     (clk_i),
        .we      (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (ram_raddr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s0_v   <= 1'b0;
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s3_v   <= 1'b0;
            s0_bin <= '0;
            s1_bin <= '0;
            s2_bin <= '0;
            s3_bin <= '0;
            s2_val <= '0;
            s3_val <= '0;
        end else begin
            s0_v   <= take_pix;
            s0_bin <= pix_i[PIX_W-1 -: BIN_BITS];
            s1_v   <= s0_v;
            s1_bin <= s0_bin;
            s2_v   <= s1_v;
            s2_bin <= s1_bin;
            s2_val <= s1_new;
            s3_v   <= s2_v;
            s3_bin <= s2_bin;
            s3_val <= s2_val;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= CLEAR;
            fv_q         <= 1'b0;
            clr_addr     <= '0;
            dump_addr    <= '0;
            drain_cnt    <= 1'b0;
            dump_ld      <= 1'b0;
            hist_data_o  <= '0;
            hist_bin_o   <= '0;
            hist_valid_o <= 1'b0;
            hist_last_o  <= 1'b0;
            busy_o       <= 1'b0;
            drop_o       <= 1'b0;
`ifdef HIST_SUM_EN
            total        <= '0;
            trailer      <= 1'b0;
`endif
        end else begin
            fv_q   <= fv_i;
            drop_o <= fv_rise & (state != IDLE);
`ifdef HIST_SUM_EN
            if (take_pix && (total != '1)) begin
                total <= total + 1'b1;
            end
`endif
            case (state)
                CLEAR: begin
                    busy_o   <= 1'b1;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_BIN) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                IDLE: begin
                    busy_o <= 1'b0;
                    if (fv_rise) begin
                        state  <= ACCUM;
                        busy_o <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (fv_fall) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state     <= DUMP;
                        dump_addr <= '0;
                        dump_ld   <= 1'b0;
                    end
                end
                DUMP: begin
                    if (accept) begin
                        hist_valid_o <= 1'b0;
                        hist_last_o  <= 1'b0;
`ifdef HIST_SUM_EN
                        if (trailer) begin
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                            trailer <= 1'b0;
                            total   <= '0;
                        end else begin
                            dump_addr <= dump_addr + 1'b1;
                            dump_ld   <= 1'b1;
                            if (dump_addr == LAST_BIN) begin
                                trailer <= 1'b1;
                            end
                        end
`else
                        if (dump_addr == LAST_BIN) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            dump_addr <= dump_addr + 1'b1;
                            dump_ld   <= 1'b1;
                        end
`endif
                    end else if (!hist_valid_o) begin
                        if (dump_ld) begin
                            dump_ld      <= 1'b0;
                            hist_valid_o <= 1'b1;
`ifdef HIST_SUM_EN
                            if (trailer) begin
                                hist_bin_o  <= '1;
                                hist_data_o <= total[CNT_W-1:0];
                                hist_last_o <= 1'b1;
                            end else begin
                                hist_bin_o  <= dump_addr;
                                hist_data_o <= rd_data;
                                hist_last_o <= 1'b0;
                            end
`else
                            hist_bin_o  <= dump_addr;
                            hist_data_o <= rd_data;
                            hist_last_o <= (dump_addr == LAST_BIN);
`endif
                        end else begin
                            dump_ld <= 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
